// File: rtl/uart_hd_link_ctrl.sv
// -----------------------------------------------------------------------------
// uart_hd_link_ctrl
//
// Line-direction arbiter for a UART that can run simplex, half-duplex or
// full-duplex. In half-duplex it owns the shared line through an
// IDLE / DIST / LOCAL / GUARD state machine. DIST means the remote end is
// talking. LOCAL means we are talking. GUARD is a quiet turnaround period
// before the line may be claimed again. All outputs are registered.
//
// Request/grant handshake: tx_req_i is a level request from the TX engine.
// tx_grant_o is a registered permission that reflects the request sampled
// on the previous edge. The TX engine may start a frame on any cycle where
// both are high, and must then hold tx_busy_i high until the frame has left
// the shifter.
//
// Ports
//   clk, rst_n      : rising-edge clock; asynchronous active-low reset
//   mode_i          : 00 simplex, 01 half-duplex, 1x full-duplex
//   master_i        : simplex direction (1 = TX-only, 0 = RX-only)
//   flow_control_i  : enables RTS/CTS handling
//   divider_i       : clk cycles per bit minus one
//   guard_bits_i    : turnaround guard length in bit periods
//   tx_req_i        : TX engine has a frame pending
//   tx_busy_i       : TX shifter is mid-frame
//   rx_busy_i       : RX engine is mid-frame
//   rx_fifo_full_i  : RX FIFO cannot accept data
//   cts_n_i         : remote clear-to-send (active-low, asynchronous)
//   tx_grant_o      : TX engine may start a frame
//   rx_en_o         : RX sampling enable
//   line_oe_o       : TX pad driver enable
//   rts_n_o         : local ready-to-receive (active-low)
//   state_o         : FSM state (0 IDLE, 1 DIST, 2 LOCAL, 3 GUARD)
// -----------------------------------------------------------------------------
module uart_hd_link_ctrl #(
   parameter int DIV_W   = 16,
   parameter int GUARD_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         mode_i,
   input  logic               master_i,
   input  logic               flow_control_i,
   input  logic [DIV_W-1:0]   divider_i,
   input  logic [GUARD_W-1:0] guard_bits_i,
   input  logic               tx_req_i,
   input  logic               tx_busy_i,
   input  logic               rx_busy_i,
   input  logic               rx_fifo_full_i,
   input  logic               cts_n_i,
   output logic               tx_grant_o,
   output logic               rx_en_o,
   output logic               line_oe_o,
   output logic               rts_n_o,
   output logic [1:0]         state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIST  = 2'd1,
      ST_LOCAL = 2'd2,
      ST_GUARD = 2'd3
   } state_t;

   localparam logic [GUARD_W-1:0] GUARD_ONE = GUARD_W'(1);

   state_t             state_q, state_d;
   logic               cts_s1_q, cts_s2_q;
   logic               cts_ok;
   logic [1:0]         mode_q;
   logic               master_q;
   logic               mode_vld_q;
   logic               mode_chg;
   logic               is_hd, is_sx;
   logic [DIV_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
   logic [GUARD_W-1:0] guard_len_q, guard_len_d;
   logic               bit_wrap, guard_done, guard_entry;
   logic               grant_d, rx_en_d, oe_d, rts_d;

   assign is_hd  = (mode_i == 2'b01);
   assign is_sx  = (mode_i == 2'b00);
   assign cts_ok = !flow_control_i || !cts_s2_q;

   // mode_vld_q masks the first edge after reset, so the block starts
   // directly in the selected mode instead of taking a spurious guard period.
   assign mode_chg = mode_vld_q && ((mode_i != mode_q) || (master_i != master_q));

   // Guard timing uses the divider and guard length captured on entry.
   assign bit_wrap   = (bit_cnt_q == div_q);
   assign guard_done = (guard_len_q == '0) ||
                       (bit_wrap && (guard_cnt_q == guard_len_q - GUARD_ONE));

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (mode_chg) begin
         state_d = ST_GUARD;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (is_hd) begin
                  if (rx_busy_i)                state_d = ST_DIST;
                  else if (tx_req_i && cts_ok)  state_d = ST_LOCAL;
               end
            end
            ST_DIST: begin
               if (!is_hd)          state_d = ST_IDLE;
               else if (!rx_busy_i) state_d = ST_GUARD;
            end
            ST_LOCAL: begin
               if (!is_hd)                                      state_d = ST_IDLE;
               else if (!tx_busy_i && (!tx_req_i || !cts_ok))  state_d = ST_GUARD;
            end
            ST_GUARD: begin
               if (guard_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A mode change while already guarding restarts the dwell.
   assign guard_entry = (state_d == ST_GUARD) && ((state_q != ST_GUARD) || mode_chg);

   // Guard counters: cleared on entry, counting only while guarding.
   always_comb begin
      bit_cnt_d   = '0;
      guard_cnt_d = '0;
      div_d       = div_q;
      guard_len_d = guard_len_q;
      if (guard_entry) begin
         div_d       = divider_i;
         guard_len_d = guard_bits_i;
      end else if ((state_q == ST_GUARD) && (state_d == ST_GUARD)) begin
         if (bit_wrap) begin
            guard_cnt_d = guard_cnt_q + GUARD_ONE;
         end else begin
            bit_cnt_d   = bit_cnt_q + DIV_W'(1);
            guard_cnt_d = guard_cnt_q;
         end
      end
   end

   // Outputs are decoded from the state being entered, so the registered
   // outputs always agree with state_o.
   always_comb begin
      grant_d = 1'b0;
      rx_en_d = 1'b0;
      oe_d    = 1'b0;
      if (state_d != ST_GUARD) begin
         if (mode_i[1]) begin
            rx_en_d = 1'b1;
            oe_d    = 1'b1;
            grant_d = tx_req_i && cts_ok;
         end else if (is_sx) begin
            if (master_i) begin
               oe_d    = 1'b1;
               grant_d = tx_req_i && cts_ok;
            end else begin
               rx_en_d = 1'b1;
            end
         end else if (state_d == ST_LOCAL) begin
            oe_d    = 1'b1;
            grant_d = tx_req_i && cts_ok && !tx_busy_i;
         end else begin
            rx_en_d = 1'b1;
         end
      end
      rts_d = flow_control_i &&
              (rx_fifo_full_i ||
               (is_hd && ((state_d == ST_LOCAL) || (state_d == ST_GUARD))) ||
               (is_sx && master_i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cts_s1_q    <= 1'b1;
         cts_s2_q    <= 1'b1;
         mode_q      <= 2'b00;
         master_q    <= 1'b0;
         mode_vld_q  <= 1'b0;
         bit_cnt_q   <= '0;
         guard_cnt_q <= '0;
         div_q       <= '0;
         guard_len_q <= '0;
         tx_grant_o  <= 1'b0;
         rx_en_o     <= 1'b0;
         line_oe_o   <= 1'b0;
         rts_n_o     <= 1'b1;
      end else begin
         state_q     <= state_d;
         cts_s1_q    <= cts_n_i;
         cts_s2_q    <= cts_s1_q;
         mode_q      <= mode_i;
         master_q    <= master_i;
         mode_vld_q  <= 1'b1;
         bit_cnt_q   <= bit_cnt_d;
         guard_cnt_q <= guard_cnt_d;
         div_q       <= div_d;
         guard_len_q <= guard_len_d;
         tx_grant_o  <= grant_d;
         rx_en_o     <= rx_en_d;
         line_oe_o   <= oe_d;
         rts_n_o     <= rts_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: doc/uart_hd_link_ctrl.md
UART_HD_LINK_CTRL -- requirements
Module: uart_hd_link_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the baud divider input.
REQ-002 SHALL have parameter GUARD_W, default 4, width of the guard-time field in bit periods.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port mode_i  input  2  link mode: 00 SIMPLEX, 01 HALFDUPLEX, 10 FULLDUPLEX; 11 treated as FULLDUPLEX.
REQ-006 SHALL have port master_i  input  1  SIMPLEX only: 1 TX-only, 0 RX-only.
REQ-007 SHALL have port flow_control_i  input  1  1 enables RTS/CTS handling.
REQ-008 SHALL have port divider_i  input  DIV_W  clk cycles per bit minus one.
REQ-009 SHALL have port guard_bits_i  input  GUARD_W  line turnaround guard, in bit periods.
REQ-010 SHALL have port tx_req_i  input  1  TX engine has a frame pending.
REQ-011 SHALL have port tx_busy_i  input  1  TX shifter is mid-frame.
REQ-012 SHALL have port rx_busy_i  input  1  RX engine has detected a start bit and is mid-frame.
REQ-013 SHALL have port rx_fifo_full_i  input  1  RX FIFO cannot accept data.
REQ-014 SHALL have port cts_n_i  input  1  remote clear-to-send, active-low, asynchronous.
REQ-015 SHALL have port tx_grant_o  output  1  TX engine may start a frame.
REQ-016 SHALL have port rx_en_o  output  1  RX engine sampling enabled.
REQ-017 SHALL have port line_oe_o  output  1  TX pad driver enable.
REQ-018 SHALL have port rts_n_o  output  1  local ready-to-receive, active-low.
REQ-019 SHALL have port state_o  output  2  FSM state: 0 IDLE, 1 DIST, 2 LOCAL, 3 GUARD.

Function
REQ-020 SHALL register all outputs; each output reflects inputs sampled on the previous edge.
REQ-021 SHALL synchronise cts_n_i through two flops into cts_ok = flow_control_i==0 OR synced cts_n==0.
REQ-022 SHALL in FULLDUPLEX: state IDLE, rx_en_o=1, line_oe_o=1, tx_grant_o = tx_req_i AND cts_ok.
REQ-023 SHALL in SIMPLEX master=1: rx_en_o=0, line_oe_o=1, tx_grant_o = tx_req_i AND cts_ok; master=0: rx_en_o=1, line_oe_o=0, tx_grant_o=0.
REQ-024 SHALL in HALFDUPLEX run FSM IDLE/DIST/LOCAL/GUARD.
REQ-025 SHALL in IDLE drive line_oe_o=0, rx_en_o=1, tx_grant_o=0; rx_busy_i=1 -> DIST; else tx_req_i AND cts_ok -> LOCAL; rx_busy_i wins when both are set.
REQ-026 SHALL in LOCAL drive line_oe_o=1, rx_en_o=0, tx_grant_o = tx_req_i AND cts_ok AND NOT tx_busy_i.
REQ-027 SHALL leave LOCAL for GUARD when tx_busy_i=0 and either tx_req_i=0 or cts_ok=0; never while tx_busy_i=1.
REQ-028 SHALL in DIST drive line_oe_o=0, rx_en_o=1, tx_grant_o=0; rx_busy_i=0 -> GUARD.
REQ-029 SHALL in GUARD drive line_oe_o=0, rx_en_o=0, tx_grant_o=0 and dwell guard_bits_i*(divider_i+1) cycles, then go to IDLE; guard_bits_i=0 dwells 1 cycle.
REQ-030 SHALL implement GUARD timing with a bit-tick counter 0..divider_i and a guard counter, both cleared on GUARD entry and idle elsewhere.
REQ-031 SHALL drive rts_n_o=1 when flow_control_i=0 is false and (rx_fifo_full_i=1 or HALFDUPLEX state in LOCAL/GUARD or SIMPLEX master=1); else rts_n_o=0.
REQ-032 SHALL drive rts_n_o=0 when flow_control_i=0.
REQ-033 SHALL on any change of mode_i or master_i (compared against a registered copy) force GUARD with counters reloaded, and drive tx_grant_o=0 that cycle.
REQ-034 SHALL treat divider_i and guard_bits_i as sampled on GUARD entry; mid-GUARD changes do not affect that dwell.

Reset
REQ-035 SHALL on rst_n=0 immediately set state IDLE, tx_grant_o=0, rx_en_o=0, line_oe_o=0, rts_n_o=1, counters 0, CTS synchroniser 1.
REQ-036 SHALL after rst_n release resume per mode on the first clock edge; reset mid-frame abandons the frame with no guard period.

Verification
REQ-037 SHALL cover HD, divider=3, guard=2, tx_req pulse one frame -> LOCAL, grant, tx_busy drop -> GUARD for exactly 8 cycles -> IDLE.
REQ-038 SHALL cover HD IDLE, rx_busy_i and tx_req_i rise same edge -> DIST, tx_grant_o stays 0, line_oe_o 0.
REQ-039 SHALL cover HD LOCAL, flow_control=1, cts_n_i rises mid-frame -> stays LOCAL until tx_busy_i=0, then GUARD; no new grant.
REQ-040 SHALL cover FULLDUPLEX, flow_control=1, rx_fifo_full_i 0->1 -> rts_n_o=1 one cycle later; cts_n_i 1->0 -> tx_grant_o rises 3 cycles later with tx_req_i=1.
REQ-041 SHALL cover mode_i HD->FULLDUPLEX while in LOCAL -> GUARD, guard=0 -> IDLE next cycle, then FULLDUPLEX outputs.
REQ-042 SHALL cover rst_n low during GUARD -> all outputs reset values asynchronously, state_o=0.
